// File: rtl/cpu6_mmu_bus.sv
// CPU6 memory-management and bus sequencer: page-table translation, protected-write
// blocking with a sticky fault, and a wait-state/acknowledge external bus cycle.
module cpu6_mmu_bus #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [6:0]  IO_FRAME    = 7'h7F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        busy,
  input  logic        pt_we,
  input  logic [3:0]  pt_index,
  input  logic [7:0]  pt_wdata,
  input  logic        fault_clr,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        io_sel,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        fault,
  output logic [15:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, XLATE, ACCESS, DONE} state_t;

  state_t      state_reg;
  logic [15:0] addr_reg;
  logic        we_reg;
  logic [7:0]  wdata_reg;
  logic [3:0]  wait_cnt_reg;
  logic [7:0]  rdata_reg;
  logic        ready_reg;
  logic        busy_reg;
  logic [18:0] mem_addr_reg;
  logic [7:0]  mem_wdata_reg;
  logic        mem_rd_reg;
  logic        mem_wr_reg;
  logic        io_sel_reg;
  logic        fault_reg;
  logic [15:0] fault_addr_reg;

  logic [7:0]  pt_reg [16];
  logic [7:0]  pt_entry;

  // Each entry resets to an identity mapping of its own index, unprotected.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pt
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          pt_reg[gi] <= {4'b0000, 4'(gi)};
        else if (pt_we && pt_index == 4'(gi))
          pt_reg[gi] <= pt_wdata;
      end
    end
  endgenerate

  // A same-cycle pt_we lands at the edge, so XLATE always sees the old entry.
  assign pt_entry = pt_reg[addr_reg[15:12]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      wait_cnt_reg   <= '0;
      rdata_reg      <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_rd_reg     <= 1'b0;
      mem_wr_reg     <= 1'b0;
      io_sel_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
    end else begin
      ready_reg <= 1'b0;
      if (fault_clr)
        fault_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (cpu_req) begin
            addr_reg  <= cpu_addr;
            we_reg    <= cpu_we;
            wdata_reg <= cpu_wdata;
            busy_reg  <= 1'b1;
            state_reg <= XLATE;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        XLATE: begin
          if (we_reg && pt_entry[7]) begin
            // Set after the clear above so a coincident new fault wins.
            fault_reg <= 1'b1;
            if (!fault_reg)
              fault_addr_reg <= addr_reg;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end else begin
            wait_cnt_reg  <= 4'(WAIT_STATES);
            mem_addr_reg  <= {pt_entry[6:0], addr_reg[11:0]};
            mem_wdata_reg <= wdata_reg;
            mem_rd_reg    <= ~we_reg;
            mem_wr_reg    <= we_reg;
            io_sel_reg    <= (pt_entry[6:0] == IO_FRAME);
            state_reg     <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt_reg != 4'd0) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end else if (mem_ack) begin
            if (!we_reg)
              rdata_reg <= mem_rdata;
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            io_sel_reg <= 1'b0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu_rdata  = rdata_reg;
  assign cpu_ready  = ready_reg;
  assign busy       = busy_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_rd     = mem_rd_reg;
  assign mem_wr     = mem_wr_reg;
  assign io_sel     = io_sel_reg;
  assign fault      = fault_reg;
  assign fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_cpu6_mmu_bus.sv
// Directed bench for cpu6_mmu_bus (WAIT_STATES=1): translation, IO decode, ack delay,
// write protection, ignored requests, XLATE/pt_we ordering and asynchronous reset.
module tb_cpu6_mmu_bus;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, pt_we, fault_clr, mem_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, pt_wdata, mem_rdata;
  logic [3:0]  pt_index;
  logic [7:0]  cpu_rdata, mem_wdata;
  logic        cpu_ready, busy, mem_rd, mem_wr, io_sel, fault;
  logic [18:0] mem_addr;
  logic [15:0] fault_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transaction observations, cycle 0 = the cycle cpu_req is driven.
  int          r_start, r_len, r_ready_at, r_ready_cnt;
  logic [18:0] r_addr;
  logic [7:0]  r_wd, r_rd;
  logic        r_io, r_wr_seen, r_stable, r_busy1;

  cpu6_mmu_bus #(.WAIT_STATES(1), .IO_FRAME(7'h7F)) dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .busy(busy), .pt_we(pt_we), .pt_index(pt_index),
    .pt_wdata(pt_wdata), .fault_clr(fault_clr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .io_sel(io_sel),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pt_write(input logic [3:0] idx, input logic [7:0] val);
    pt_index = idx;
    pt_wdata = val;
    pt_we    = 1'b1;
    tick();
    pt_we    = 1'b0;
  endtask

  // Issue one access; ack rises in strobe cycle ack_delay+1. Optionally pulse a
  // stray cpu_req in cycle 2 and/or write pt[pt_i] during the XLATE cycle.
  task automatic run_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                            input int ack_delay, input bit extra_req,
                            input bit pt_in_xlate, input logic [3:0] pt_i,
                            input logic [7:0] pt_d);
    r_start = -1; r_len = 0; r_ready_at = -1; r_ready_cnt = 0;
    r_addr = '0; r_wd = '0; r_rd = '0; r_io = 1'b0; r_wr_seen = 1'b0;
    r_stable = 1'b1; r_busy1 = 1'b0;
    cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
    mem_ack = (ack_delay == 0);
    tick();
    for (int c = 1; c < 40; c++) begin
      if (c == 1) r_busy1 = busy;
      if (mem_rd || mem_wr) begin
        r_len++;
        if (r_start < 0) begin
          r_start = c; r_addr = mem_addr; r_wd = mem_wdata; r_io = io_sel; r_wr_seen = mem_wr;
        end else if (mem_addr !== r_addr || mem_wdata !== r_wd || io_sel !== r_io) begin
          r_stable = 1'b0;
        end
        mem_ack = (r_len > ack_delay);
      end else begin
        mem_ack = (ack_delay == 0);
      end
      if (cpu_ready) begin
        r_ready_cnt++;
        if (r_ready_at < 0) begin
          r_ready_at = c; r_rd = cpu_rdata;
        end
      end
      cpu_req = (extra_req && c == 2);
      pt_index = pt_i; pt_wdata = pt_d;
      pt_we = (pt_in_xlate && c == 1);
      if (r_ready_at >= 0 && c >= r_ready_at + 2) break;
      tick();
    end
    cpu_req = 1'b0; pt_we = 1'b0; mem_ack = 1'b0;
    $display("txn addr=%04h we=%0d strobe_start=%0d strobe_len=%0d mem_addr=%05h io=%0d ready_at=%0d ready_cnt=%0d rdata=%02h",
             a, we, r_start, r_len, r_addr, r_io, r_ready_at, r_ready_cnt, r_rd);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pt_we = 1'b0; pt_index = '0; pt_wdata = '0; fault_clr = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_ready", cpu_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {mem_rd, mem_wr, io_sel}, 0);
    check("rst_fault", fault, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fault_addr", fault_addr, 0);
    check("rst_rdata", cpu_rdata, 0);
    reset = 1'b0;
    tick();

    // Identity-mapped read with one wait state.
    mem_rdata = 8'hA5;
    run_access(16'h1234, 1'b0, 8'h00, 0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("rd_busy", r_busy1, 1);
    check("rd_start", r_start, 2);
    check("rd_len", r_len, 2);
    check("rd_addr", r_addr, 19'h01234);
    check("rd_kind", r_wr_seen, 0);
    check("rd_ready_at", r_ready_at, 4);
    check("rd_ready_cnt", r_ready_cnt, 1);
    check("rd_data", r_rd, 8'hA5);

    // Remapped write.
    pt_write(4'd3, 8'h42);
    run_access(16'h3ABC, 1'b1, 8'h5A, 0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("wr_kind", r_wr_seen, 1);
    check("wr_addr", r_addr, 19'h42ABC);
    check("wr_data", r_wd, 8'h5A);
    check("wr_io", r_io, 0);
    check("wr_ready_at", r_ready_at, 4);
    check("wr_keeps_rdata", cpu_rdata, 8'hA5);

    // IO frame with a delayed acknowledge.
    pt_write(4'd15, 8'h7F);
    mem_rdata = 8'h3C;
    run_access(16'hF010, 1'b0, 8'h00, 5, 1'b0, 1'b0, 4'd0, 8'h00);
    check("io_sel", r_io, 1);
    check("io_addr", r_addr, 19'h7F010);
    check("io_len", r_len, 6);
    check("io_stable", r_stable, 1);
    check("io_ready_at", r_ready_at, 8);
    check("io_ready_cnt", r_ready_cnt, 1);
    check("io_data", r_rd, 8'h3C);

    // Write-protected page.
    pt_write(4'd2, 8'h85);
    run_access(16'h2000, 1'b1, 8'h11, 0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("wp_no_strobe", r_len, 0);
    check("wp_ready_at", r_ready_at, 2);
    check("wp_fault", fault, 1);
    check("wp_fault_addr", fault_addr, 16'h2000);
    check("wp_rdata_kept", r_rd, 8'h3C);
    run_access(16'h2001, 1'b1, 8'h22, 0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("wp2_no_strobe", r_len, 0);
    check("wp2_fault_addr", fault_addr, 16'h2000);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_fault_addr", fault_addr, 16'h2000);

    // Stray request during ACCESS is dropped.
    mem_rdata = 8'h77;
    run_access(16'h1234, 1'b0, 8'h00, 0, 1'b1, 1'b0, 4'd0, 8'h00);
    check("ign_ready_cnt", r_ready_cnt, 1);
    check("ign_ready_at", r_ready_at, 4);
    check("ign_busy_after", busy, 0);

    // pt_we to the active entry during XLATE: old frame used, new frame next time.
    run_access(16'h3ABC, 1'b0, 8'h00, 0, 1'b0, 1'b1, 4'd3, 8'h11);
    check("ptx_old_frame", r_addr, 19'h42ABC);
    run_access(16'h3100, 1'b0, 8'h00, 0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("ptx_new_frame", r_addr, 19'h11100);

    // Asynchronous reset in the middle of ACCESS.
    cpu_addr = 16'h3ABC; cpu_we = 1'b0; cpu_req = 1'b1; mem_ack = 1'b0;
    tick();
    cpu_req = 1'b0;
    tick();
    check("mid_rd_before", mem_rd, 1);
    reset = 1'b1;
    #1;
    check("mid_rd_after", mem_rd, 0);
    check("mid_busy_after", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    run_access(16'h3ABC, 1'b0, 8'h00, 0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("post_rst_identity", r_addr, 19'h03ABC);
    check("post_rst_ready", r_ready_at, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
